// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default constants for the pipeline controller.
package pipe_ctrl_pkg;

  // Flush sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } pipe_state_e;

  localparam int unsigned DEF_NUM_STAGES = 6;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  // Width of an index into n items; never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush/counter bus between the pipeline controller and the core stages.
interface pipeline_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
);

  localparam int unsigned SEL_W = sel_width(NUM_STAGES);

  // Core -> controller
  logic [NUM_STAGES-1:0] stall_req;
  logic                  flush_req;
  logic [ADDR_W-1:0]     flush_addr;
  logic [SEL_W-1:0]      cnt_sel;
  logic                  cnt_clr;

  // Controller -> core
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [ADDR_W-1:0]     new_pc;
  logic                  refill_busy;
  logic                  stall_timeout;
  logic [CNT_W-1:0]      cnt_rdata;

  // Controller side
  modport master (
    input  stall_req, flush_req, flush_addr, cnt_sel, cnt_clr,
    output stall, flush, new_pc, refill_busy, stall_timeout, cnt_rdata
  );

  // Core / stage side
  modport slave (
    output stall_req, flush_req, flush_addr, cnt_sel, cnt_clr,
    input  stall, flush, new_pc, refill_busy, stall_timeout, cnt_rdata
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear, else increment unless already all-ones
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// N-stage pipeline controller: stall fan-out, flush/redirect sequencing,
// refill window, per-stage stall counters and a stall watchdog.
module pipeline_ctrl import pipe_ctrl_pkg::*; #(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.master bus
);

  localparam int unsigned DRAIN_W = sel_width(NUM_STAGES);
  localparam int unsigned RUN_W   = $clog2(TIMEOUT + 1);

  pipe_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;

  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall_c;

  logic                  flush_q, flush_d;
  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     new_pc_q, new_pc_d;

  logic [RUN_W-1:0]      run_q, run_d;
  logic                  timeout_q, timeout_d;

  logic [CNT_W-1:0]      cnt_q [NUM_STAGES];
  logic [CNT_W-1:0]      sel_val;
  logic                  sel_inc;
  logic [CNT_W-1:0]      rdata_q, rdata_d;

  // Suffix-OR of requests: a stalled stage freezes itself and everything upstream
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stall
    assign stall_raw[g] = |bus.stall_req[NUM_STAGES-1:g];
  end

  // FSM state and drain counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state: a flush request from any state restarts the flush sequence
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FLUSH: begin
        state_d = DRAIN;
        drain_d = DRAIN_W'(NUM_STAGES - 2);
      end
      DRAIN: begin
        // Bubbles only advance when the PC stage is not held
        if (!stall_c[0]) begin
          if (drain_q == '0) begin
            state_d = IDLE;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.flush_req) begin
      state_d = FLUSH;
    end
  end

  // Outputs: stall forced clear during FLUSH; strobe/busy/redirect decoded from next state
  always_comb begin
    stall_c  = (state_q == FLUSH) ? '0 : stall_raw;
    flush_d  = (state_d == FLUSH);
    busy_d   = (state_d == DRAIN);
    new_pc_d = bus.flush_req ? bus.flush_addr : '0;
  end

  // Watchdog: consecutive-request run length, saturating at TIMEOUT; sticky trip
  always_comb begin
    run_d     = '0;
    timeout_d = timeout_q;
    if (|bus.stall_req) begin
      run_d = (run_q == RUN_W'(TIMEOUT)) ? run_q : run_q + RUN_W'(1);
    end
    if (run_d == RUN_W'(TIMEOUT)) begin
      timeout_d = 1'b1;
    end
  end

  // Per-stage stall-cycle counters; the forced-clear FLUSH cycle is not counted
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cnt
    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_c[g]),
      .clr (bus.cnt_clr),
      .q   (cnt_q[g])
    );
  end

  // Readback uses the selected counter's next value so updates show one cycle later
  always_comb begin
    sel_val = '0;
    sel_inc = 1'b0;
    rdata_d = '0;
    if (32'(bus.cnt_sel) < NUM_STAGES) begin
      sel_val = cnt_q[bus.cnt_sel];
      sel_inc = stall_c[bus.cnt_sel];
      if (bus.cnt_clr) begin
        rdata_d = '0;
      end else if (sel_inc && (sel_val != '1)) begin
        rdata_d = sel_val + CNT_W'(1);
      end else begin
        rdata_d = sel_val;
      end
    end
  end

  // Registered outputs and watchdog state
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      new_pc_q  <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      new_pc_q  <= new_pc_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.refill_busy   = busy_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.cnt_rdata     = rdata_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: 6 stages, 4-bit counters, TIMEOUT=8.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if #(.NUM_STAGES(6), .ADDR_W(32), .CNT_W(4)) bus ();

  pipeline_ctrl #(
    .NUM_STAGES (6),
    .ADDR_W     (32),
    .CNT_W      (4),
    .TIMEOUT    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0] req;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall_req  = '0;
    bus.flush_req  = 1'b0;
    bus.flush_addr = '0;
    bus.cnt_sel    = '0;
    bus.cnt_clr    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{req: 6'b000000, exp_stall: 6'b000000};
    vecs[1] = '{req: 6'b000001, exp_stall: 6'b000001};
    vecs[2] = '{req: 6'b000010, exp_stall: 6'b000011};
    vecs[3] = '{req: 6'b000100, exp_stall: 6'b000111};
    vecs[4] = '{req: 6'b001000, exp_stall: 6'b001111};
    vecs[5] = '{req: 6'b010000, exp_stall: 6'b011111};
    vecs[6] = '{req: 6'b100000, exp_stall: 6'b111111};
    vecs[7] = '{req: 6'b010100, exp_stall: 6'b011111};

    // Reset state
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_stall",       64'(bus.stall), 64'h0);
    check("rst_flush",       64'(bus.flush), 64'h0);
    check("rst_new_pc",      64'(bus.new_pc), 64'h0);
    check("rst_refill_busy", 64'(bus.refill_busy), 64'h0);
    check("rst_timeout",     64'(bus.stall_timeout), 64'h0);
    check("rst_cnt_rdata",   64'(bus.cnt_rdata), 64'h0);
    rst = 1'b0;

    // Combinational stall fan-out table
    for (int i = 0; i < 8; i++) begin
      bus.stall_req = vecs[i].req;
      #1;
      check($sformatf("stall_vec%0d", i), 64'(bus.stall), 64'(vecs[i].exp_stall));
      tick();
    end
    do_reset();

    // EX stall for 5 cycles, then read back all counters (6,7 out of range)
    for (int k = 0; k < 5; k++) begin
      bus.stall_req = 6'b001000;
      #1;
      check("ex_stall", 64'(bus.stall), 64'h0F);
      tick();
    end
    bus.stall_req = '0;
    for (int i = 0; i < 8; i++) begin
      bus.cnt_sel = 3'(i);
      tick();
      check($sformatf("ex_cnt%0d", i), 64'(bus.cnt_rdata), (i <= 3) ? 64'd5 : 64'd0);
    end
    bus.cnt_sel = '0;

    // Single unstalled flush
    bus.flush_req  = 1'b1;
    bus.flush_addr = 32'h0000_0040;
    #1;
    check("f1_no_early_flush", 64'(bus.flush), 64'h0);
    tick();
    bus.flush_req  = 1'b0;
    bus.flush_addr = '0;
    check("f1_flush",  64'(bus.flush), 64'h1);
    check("f1_new_pc", 64'(bus.new_pc), 64'h40);
    check("f1_busy_t1", 64'(bus.refill_busy), 64'h0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      check($sformatf("f1_busy_t%0d", k), 64'(bus.refill_busy), (k <= 6) ? 64'h1 : 64'h0);
      check($sformatf("f1_flush_t%0d", k), 64'(bus.flush), 64'h0);
    end

    // Back-to-back flushes: newest address wins, refill window restarts
    tick();
    bus.flush_req  = 1'b1;
    bus.flush_addr = 32'h0000_0040;
    tick();
    bus.flush_req  = 1'b0;
    check("f2_flush_a",  64'(bus.flush), 64'h1);
    check("f2_new_pc_a", 64'(bus.new_pc), 64'h40);
    tick();
    check("f2_busy_t2", 64'(bus.refill_busy), 64'h1);
    tick();
    bus.flush_req  = 1'b1;
    bus.flush_addr = 32'h0000_0080;
    check("f2_busy_t3", 64'(bus.refill_busy), 64'h1);
    tick();
    bus.flush_req  = 1'b0;
    bus.flush_addr = '0;
    check("f2_flush_b",  64'(bus.flush), 64'h1);
    check("f2_new_pc_b", 64'(bus.new_pc), 64'h80);
    check("f2_busy_t4",  64'(bus.refill_busy), 64'h0);
    for (int k = 5; k <= 10; k++) begin
      tick();
      check($sformatf("f2_busy_t%0d", k), 64'(bus.refill_busy), (k <= 9) ? 64'h1 : 64'h0);
    end

    // Flush together with a stall: FLUSH cycle forces stall clear and is not counted
    do_reset();
    bus.stall_req  = 6'b001000;
    bus.flush_req  = 1'b1;
    bus.flush_addr = 32'h0000_0100;
    bus.cnt_sel    = 3'd3;
    #1;
    check("fs_stall_req_cycle", 64'(bus.stall), 64'h0F);
    tick();
    bus.flush_req  = 1'b0;
    bus.flush_addr = '0;
    #1;
    check("fs_flush",        64'(bus.flush), 64'h1);
    check("fs_new_pc",       64'(bus.new_pc), 64'h100);
    check("fs_stall_forced", 64'(bus.stall), 64'h0);
    tick();
    check("fs_stall_drain", 64'(bus.stall), 64'h0F);
    check("fs_busy_t2",     64'(bus.refill_busy), 64'h1);
    tick();
    bus.stall_req = '0;
    for (int k = 3; k <= 8; k++) begin
      check($sformatf("fs_busy_t%0d", k), 64'(bus.refill_busy), (k <= 7) ? 64'h1 : 64'h0);
      tick();
    end
    check("fs_cnt3", 64'(bus.cnt_rdata), 64'd2);

    // Watchdog: 7-cycle run, gap, 8-cycle run trips; sticky until reset
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.stall_req = 6'b000100;
      check("wd_run7_low", 64'(bus.stall_timeout), 64'h0);
      tick();
    end
    bus.stall_req = '0;
    check("wd_gap_low", 64'(bus.stall_timeout), 64'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.stall_req = 6'b000100;
      check($sformatf("wd_run8_low%0d", k), 64'(bus.stall_timeout), 64'h0);
      tick();
    end
    bus.stall_req = '0;
    check("wd_trip", 64'(bus.stall_timeout), 64'h1);
    tick();
    tick();
    tick();
    check("wd_sticky", 64'(bus.stall_timeout), 64'h1);
    do_reset();
    check("wd_cleared_by_rst", 64'(bus.stall_timeout), 64'h0);

    // Counter saturation with 4-bit counters, then clear beats a concurrent stall
    bus.cnt_sel = 3'd3;
    for (int k = 0; k < 20; k++) begin
      bus.stall_req = 6'b001000;
      tick();
    end
    bus.stall_req = '0;
    tick();
    check("sat_cnt3", 64'(bus.cnt_rdata), 64'd15);
    bus.stall_req = 6'b001000;
    bus.cnt_clr   = 1'b1;
    tick();
    check("clr_cnt3", 64'(bus.cnt_rdata), 64'd0);
    bus.stall_req = '0;
    bus.cnt_clr   = 1'b0;
    bus.cnt_sel   = 3'd0;
    tick();
    check("clr_cnt0", 64'(bus.cnt_rdata), 64'd0);

    // Reset during DRAIN: everything returns to reset values, no further strobe
    do_reset();
    bus.flush_req  = 1'b1;
    bus.flush_addr = 32'h0000_0040;
    tick();
    bus.flush_req  = 1'b0;
    bus.flush_addr = '0;
    check("rf_flush", 64'(bus.flush), 64'h1);
    tick();
    check("rf_busy", 64'(bus.refill_busy), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_flush_cleared",  64'(bus.flush), 64'h0);
    check("rf_busy_cleared",   64'(bus.refill_busy), 64'h0);
    check("rf_new_pc_cleared", 64'(bus.new_pc), 64'h0);
    check("rf_stall_cleared",  64'(bus.stall), 64'h0);
    check("rf_rdata_cleared",  64'(bus.cnt_rdata), 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rf_no_flush%0d", k), 64'(bus.flush), 64'h0);
      check($sformatf("rf_no_busy%0d", k),  64'(bus.refill_busy), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
